fact_mmio_unit: RTL

- Memory-mapped iterative factorial engine on the MIPS data bus; the core writes n and a go strobe, polls status, then reads n!.
- Supplies the accelerator result that system-level benches probe through the done output.
- One multiply per cycle, with an overflow guard against a configured maximum n.

---
 rtl/fact_pkg.sv | 21 ++
 rtl/fact_engine.sv | 108 ++++++++++
 rtl/fact_mmio_unit.sv | 71 +++++++
 3 files changed

// File: rtl/fact_pkg.sv
// Shared constants for the memory-mapped factorial unit: FSM encodings,
// register word offsets and STATUS bit positions.
package fact_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fact_state_e;

  localparam logic [2:0] FACT_N      = 3'd0;
  localparam logic [2:0] FACT_GO     = 3'd1;
  localparam logic [2:0] FACT_STATUS = 3'd2;
  localparam logic [2:0] FACT_RESULT = 3'd3;
  localparam logic [2:0] FACT_CYCLES = 3'd4;

  localparam int STATUS_DONE_BIT = 0;
  localparam int STATUS_ERR_BIT  = 1;
  localparam int STATUS_BUSY_BIT = 2;

endpackage

// File: rtl/fact_engine.sv
// Iterative factorial engine: one multiply per cycle, error on n > MAX_N.
// Optional cycle counter is built only when FACT_CYCLE_CNT_EN is defined.
module fact_engine
  import fact_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_W    = 4,
  parameter int MAX_N  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_W-1:0]    n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] cycles,
  output fact_state_e       state_dbg
);

  // start is a single-cycle request; it is accepted only in IDLE or DONE and
  // silently dropped while BUSY. done/err stay valid until the next accepted start.
  fact_state_e          state_q, state_d;
  logic [N_W-1:0]       cnt;
  logic [DATA_W-1:0]    product;
  logic                 do_load, do_error, do_step, do_finish;

  always_comb begin
    state_d   = state_q;
    do_load   = 1'b0;
    do_error  = 1'b0;
    do_step   = 1'b0;
    do_finish = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (int'(n) > MAX_N) begin
            state_d  = ST_DONE;
            do_error = 1'b1;
          end else begin
            state_d = ST_BUSY;
            do_load = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (cnt <= N_W'(1)) begin
          state_d   = ST_DONE;
          do_finish = 1'b1;
        end else begin
          do_step = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (do_error) begin
        product <= '0;
        done    <= 1'b1;
        err     <= 1'b1;
      end else if (do_load) begin
        cnt     <= n;
        product <= DATA_W'(1);
        done    <= 1'b0;
        err     <= 1'b0;
      end else if (do_step) begin
        product <= product * {{(DATA_W-N_W){1'b0}}, cnt};
        cnt     <= cnt - N_W'(1);
      end else if (do_finish) begin
        done <= 1'b1;
      end
    end
  end

`ifdef FACT_CYCLE_CNT_EN
  logic [DATA_W-1:0] cycle_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
    end else if (do_load || do_error) begin
      cycle_q <= '0;
    end else if (state_q == ST_BUSY) begin
      cycle_q <= cycle_q + DATA_W'(1);
    end
  end

  assign cycles = cycle_q;
`else
  assign cycles = '0;
`endif

  assign busy      = (state_q == ST_BUSY);
  assign result    = product;
  assign state_dbg = state_q;

endmodule

// File: rtl/fact_mmio_unit.sv
// Bus-facing register decode and read mux for the factorial engine.
// Optional CYCLES register depends on FACT_CYCLE_CNT_EN (see fact_engine).
module fact_mmio_unit
  import fact_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_W    = 4,
  parameter int MAX_N  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              sel,
  input  logic [2:0]        addr,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd,
  output logic              done,
  output logic              busy
);

  logic [N_W-1:0]    n_reg;
  logic              wr, start, err;
  logic [DATA_W-1:0] result, cycles;
  fact_state_e       state_dbg_unused;
  logic              wd_unused;

  assign wr        = we && sel;
  assign start     = wr && (addr == FACT_GO) && wd[0];
  assign wd_unused = ^wd[DATA_W-1:N_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg <= '0;
    end else if (wr && addr == FACT_N) begin
      n_reg <= wd[N_W-1:0];
    end
  end

  fact_engine #(
    .DATA_W (DATA_W),
    .N_W    (N_W),
    .MAX_N  (MAX_N)
  ) u_engine (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .n         (n_reg),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .result    (result),
    .cycles    (cycles),
    .state_dbg (state_dbg_unused)
  );

  always_comb begin
    rd = '0;
    case (addr)
      FACT_N:      rd = {{(DATA_W-N_W){1'b0}}, n_reg};
      FACT_STATUS: begin
        rd[STATUS_DONE_BIT] = done;
        rd[STATUS_ERR_BIT]  = err;
        rd[STATUS_BUSY_BIT] = busy;
      end
      FACT_RESULT: rd = result;
      FACT_CYCLES: rd = cycles;
      default:     rd = '0;
    endcase
  end

endmodule
